// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control/status bundle for the loadable down-counter/timer.
// The master side (controller, testbench) drives load/start/pause, the slave side
// (the timer) returns count, busy and the one-cycle done pulse.
interface down_counter_timer_if #(
   parameter int unsigned WIDTH = 3
);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             pause;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output load,
      output load_val,
      output start,
      output pause,
      input  count,
      input  busy,
      input  done
   );

   modport slave (
      input  load,
      input  load_val,
      input  start,
      input  pause,
      output count,
      output busy,
      output done
   );
endinterface : down_counter_timer_if

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable WIDTH-bit down-counter used as a timeout/delay primitive.
// A loaded value counts down to zero after a start request, one step per clock; a
// registered one-cycle done pulse marks terminal count, and pause freezes the count.
//
// Optional build macro:
//   DOWN_COUNTER_AUTO_RELOAD_EN - when defined, the terminal edge in RUN reloads the
//   last loaded value (if non-zero) and keeps running, giving a periodic done pulse.
//   When undefined (default), the counter is one-shot and returns to IDLE at zero.
//
// Edge priority: load > pause > start > count.
module down_counter_timer #(
   parameter int unsigned WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   down_counter_timer_if.slave  bus
);

   // FSM encoding kept as plain constants for compatibility with older flows.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q,  done_d;
   logic             busy_q,  busy_d;
   logic             terminal_s;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   // The reload copy is only observable when auto-reload is built in.
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   // Terminal count is detected one step early (at 1) so the count never wraps.
   // A zero count in RUN cannot be reached, but is treated as terminal as well so
   // that a corrupted state can never underflow.
   always_comb begin
      if (count_q <= ONE) begin
         terminal_s = 1'b1;
      end else begin
         terminal_s = 1'b0;
      end
   end

   // Next-state, next-count and done decode, in load > pause > start > count order.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif

      if (bus.load) begin
         // Load wins over everything: capture value, abandon any run, no done.
         count_d = bus.load_val;
         state_d = ST_IDLE;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         reload_d = bus.load_val;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.pause) begin
                  // Pause outranks start, so a start while paused is ignored.
                  state_d = ST_IDLE;
               end else if (bus.start) begin
                  if (count_q != ZERO) begin
                     // The start edge only arms the run; first decrement is next edge.
                     state_d = ST_RUN;
                  end else begin
                     // Nothing to count: report terminal count straight away.
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end

            ST_RUN: begin
               if (bus.pause) begin
                  state_d = ST_HOLD;
               end else if (terminal_s) begin
                  done_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                  if (reload_q != ZERO) begin
                     // Periodic mode: restart from the loaded value without a gap.
                     count_d = reload_q;
                     state_d = ST_RUN;
                  end else begin
                     count_d = ZERO;
                     state_d = ST_IDLE;
                  end
`else
                  count_d = ZERO;
                  state_d = ST_IDLE;
`endif
               end else begin
                  count_d = count_q - ONE;
               end
            end

            ST_HOLD: begin
               if (bus.pause) begin
                  state_d = ST_HOLD;
               end else begin
                  // Resume edge: back to RUN, decrement resumes on the next edge.
                  state_d = ST_RUN;
               end
            end

            default: begin
               // Unreachable encoding: fall back to a safe idle state, no done.
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // busy is registered alongside the state so it matches the state register exactly.
   always_comb begin
      if (state_d != ST_IDLE) begin
         busy_d = 1'b1;
      end else begin
         busy_d = 1'b0;
      end
   end

   // State, count, reload copy and output flags, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= ZERO;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         reload_q <= ZERO;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign bus.count = count_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed and randomized checks of down_counter_timer against
// a small behavioural model (running/held flags plus an integer count).
module tb_down_counter_timer;
   localparam int unsigned W = 3;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // Reference model state
   int   m_count;
   int   m_reload;
   bit   m_active;
   bit   m_held;
   bit   m_done;

   down_counter_timer_if #(.WIDTH(W)) bus_if ();

   down_counter_timer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".count"}, int'(bus_if.count), m_count);
      chk({tag, ".busy"},  int'(bus_if.busy),  int'(m_active));
      chk({tag, ".done"},  int'(bus_if.done),  int'(m_done));
   endtask

   task automatic model_reset();
      m_count  = 0;
      m_reload = 0;
      m_active = 1'b0;
      m_held   = 1'b0;
      m_done   = 1'b0;
   endtask

   // One clock edge of the behavioural model.
   task automatic model_edge(input bit ld, input int v, input bit st, input bit ps);
      m_done = 1'b0;
      if (ld) begin
         m_count  = v;
         m_reload = v;
         m_active = 1'b0;
         m_held   = 1'b0;
      end else if (!m_active) begin
         if (!ps && st) begin
            if (m_count == 0) m_done = 1'b1;
            else              m_active = 1'b1;
         end
      end else if (m_held) begin
         if (!ps) m_held = 1'b0;
      end else if (ps) begin
         m_held = 1'b1;
      end else if (m_count == 1) begin
         m_done = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         if (m_reload != 0) begin
            m_count = m_reload;
         end else begin
            m_count  = 0;
            m_active = 1'b0;
         end
`else
         m_count  = 0;
         m_active = 1'b0;
`endif
      end else begin
         m_count = m_count - 1;
      end
   endtask

   // Drive one set of inputs for one edge, advance the model, check outputs.
   task automatic step(input string tag, input bit ld, input int v, input bit st, input bit ps);
      @(negedge clk);
      bus_if.load     = ld;
      bus_if.load_val = W'(v);
      bus_if.start    = st;
      bus_if.pause    = ps;
      @(posedge clk);
      model_edge(ld, v, st, ps);
      #1;
      chk_all(tag);
   endtask

   initial begin
      bit ld, st, ps;
      int v;
      checks = 0;
      errors = 0;
      model_reset();
      bus_if.load     = 1'b0;
      bus_if.load_val = '0;
      bus_if.start    = 1'b0;
      bus_if.pause    = 1'b0;

      // 1. Reset held for two edges
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst.count", int'(bus_if.count), 0);
      chk("rst.busy",  int'(bus_if.busy),  0);
      chk("rst.done",  int'(bus_if.done),  0);
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset mid-run at count=4
      step("ar.load", 1'b1, 7, 1'b0, 1'b0);
      step("ar.start", 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("ar.run", 1'b0, 0, 1'b0, 1'b0);
      chk("ar.at4", int'(bus_if.count), 4);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all("ar.async");
      @(negedge clk);
      rst_n = 1'b1;
      step("ar.after", 1'b0, 0, 1'b0, 1'b0);

      // 2. Load 5, start, count 5..0, done at 0 with busy falling
      step("t2.load", 1'b1, 5, 1'b0, 1'b0);
      step("t2.start", 1'b0, 0, 1'b1, 1'b0);
      chk("t2.first", int'(bus_if.count), 5);
      for (int i = 0; i < 5; i++) step("t2.run", 1'b0, 0, 1'b0, 1'b0);
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
      chk("t2.zero", int'(bus_if.count), 0);
      chk("t2.done", int'(bus_if.done), 1);
      chk("t2.busy", int'(bus_if.busy), 0);
`endif
      step("t2.idle", 1'b1, 0, 1'b0, 1'b0);

      // 3. Load 7, pause at 5 for 3 edges, release
      step("t3.load", 1'b1, 7, 1'b0, 1'b0);
      step("t3.start", 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step("t3.run", 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("t3.hold", 1'b0, 0, 1'b0, 1'b1);
      chk("t3.held", int'(bus_if.count), 5);
      chk("t3.busy", int'(bus_if.busy), 1);
      step("t3.resume", 1'b0, 0, 1'b0, 1'b0);
      chk("t3.resume5", int'(bus_if.count), 5);
      step("t3.dec", 1'b0, 0, 1'b0, 1'b0);
      chk("t3.dec4", int'(bus_if.count), 4);
      step("t3.start_in_run", 1'b0, 0, 1'b1, 1'b0);

      // 4. Load 0, start -> single done, busy stays 0
      step("t4.load", 1'b1, 0, 1'b0, 1'b0);
      step("t4.start", 1'b0, 0, 1'b1, 1'b0);
      chk("t4.done", int'(bus_if.done), 1);
      chk("t4.busy", int'(bus_if.busy), 0);
      step("t4.after", 1'b0, 0, 1'b0, 1'b0);
      chk("t4.done_off", int'(bus_if.done), 0);

      // 5. Load during run with start asserted -> load wins
      step("t5.load", 1'b1, 7, 1'b0, 1'b0);
      step("t5.start", 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step("t5.run", 1'b0, 0, 1'b0, 1'b0);
      step("t5.reload", 1'b1, 6, 1'b1, 1'b1);
      chk("t5.count", int'(bus_if.count), 6);
      chk("t5.busy", int'(bus_if.busy), 0);
      chk("t5.done", int'(bus_if.done), 0);

      // 6. Load 3, run long: periodic with auto-reload, stops at 0 otherwise
      step("t6.load", 1'b1, 3, 1'b0, 1'b0);
      step("t6.start", 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step("t6.run", 1'b0, 0, 1'b0, 1'b0);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      chk("t6.busy", int'(bus_if.busy), 1);
`else
      chk("t6.stop", int'(bus_if.count), 0);
`endif

      // Randomized mix of load/start/pause
      for (int i = 0; i < 400; i++) begin
         ld = ($urandom_range(0, 11) == 0);
         v  = int'($urandom_range(0, (1 << W) - 1));
         st = ($urandom_range(0, 3) == 0);
         ps = ($urandom_range(0, 4) == 0);
         step("rnd", ld, v, st, ps);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule : tb_down_counter_timer
